// File: rtl/dmem_arbiter_if.sv
// One master's port into the data-memory arbiter: request/address/data in,
// grant, stall and read response back.
interface dmem_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wr_en;
    logic        gnt;
    logic        stall;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, wdata, wr_en,
        input  gnt, stall, rvalid, rdata
    );

    modport slave (
        input  req, addr, wdata, wr_en,
        output gnt, stall, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single synchronous-read data-memory port, with a
// bounded burst per owner and read responses steered back to their issuer.
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  m0,
    dmem_arbiter_if.slave  m1,
    output logic [31:0]    mem_addr,
    output logic [31:0]    mem_dout,
    output logic [3:0]     mem_wr_en,
    input  logic [31:0]    mem_din,
    output logic           busy
);

    localparam logic [3:0] LIMIT = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        pend_vld;
    logic        pend_id;

    logic        gnt0;
    logic        gnt1;
    logic        beat;
    logic        owner_change;

    // Owner keeps the port until it has taken LIMIT beats while the other waits.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (m0.req && m1.req) begin
            case (state)
                OWN0:    if (cnt < LIMIT) gnt0 = 1'b1; else gnt1 = 1'b1;
                OWN1:    if (cnt < LIMIT) gnt1 = 1'b1; else gnt0 = 1'b1;
                default: gnt0 = 1'b1;
            endcase
        end else if (m0.req) begin
            gnt0 = 1'b1;
        end else if (m1.req) begin
            gnt1 = 1'b1;
        end
    end

    assign beat         = gnt0 | gnt1;
    assign owner_change = (state == IDLE) || (state == OWN0 && gnt1) || (state == OWN1 && gnt0);

    always_comb begin
        mem_addr  = 32'd0;
        mem_dout  = 32'd0;
        mem_wr_en = 4'd0;
        if (gnt0) begin
            mem_addr  = m0.addr;
            mem_dout  = m0.wdata;
            mem_wr_en = m0.wr_en;
        end else if (gnt1) begin
            mem_addr  = m1.addr;
            mem_dout  = m1.wdata;
            mem_wr_en = m1.wr_en;
        end
    end

    // Memory latency is one cycle, so a single pending slot is enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            pend_vld <= 1'b0;
            pend_id  <= 1'b0;
        end else if (beat) begin
            state <= gnt1 ? OWN1 : OWN0;
            if (owner_change) begin
                cnt <= 4'd1;
            end else if (cnt != 4'd15) begin
                cnt <= cnt + 4'd1;
            end
            pend_vld <= (mem_wr_en == 4'd0);
            if (mem_wr_en == 4'd0) begin
                pend_id <= gnt1;
            end
        end else begin
            state    <= IDLE;
            pend_vld <= 1'b0;
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.stall  = m0.req & ~gnt0;
    assign m1.stall  = m1.req & ~gnt1;
    assign m0.rvalid = pend_vld & ~pend_id;
    assign m1.rvalid = pend_vld & pend_id;
    assign m0.rdata  = mem_din;
    assign m1.rdata  = mem_din;
    assign busy      = pend_vld;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter in front of the data-memory port. It shares the single synchronous-read memory interface between the CPU memory stage (master 0) and a secondary master such as a boot loader or debug DMA (master 1). It issues at most one access per cycle, bounds how long one master can hold the port while the other waits, and routes each read response back to the master that issued it. Its memory-side outputs drive the address, write-data and byte-enable inputs of the data-memory control block; read data returns on `mem_din`.

## Interface
- `MAX_BURST`, 8: maximum consecutive beats one master may take while the other is requesting; legal range 1–15.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `m0_req` in 1: CPU access request, level-held until granted.
- `m0_addr` in 32: CPU byte address.
- `m0_wdata` in 32: CPU write data, already lane-replicated.
- `m0_wr_en` in 4: CPU byte write enables; 0 means read.
- `m0_gnt` out 1: combinational; the beat is issued this cycle.
- `m0_stall` out 1: equals `m0_req & ~m0_gnt`.
- `m0_rvalid` out 1: registered; read data for master 0 is valid on `m0_rdata`.
- `m0_rdata` out 32: equals `mem_din`.
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_wr_en`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as the master 0 signals, for master 1.
- `mem_addr` out 32: memory address.
- `mem_dout` out 32: memory write data.
- `mem_wr_en` out 4: memory byte write enables.
- `mem_din` in 32: memory read data, valid one cycle after the read address.
- `busy` out 1: high while any read response is still pending.

## Operation
- Beat: a cycle in which `mX_req` and `mX_gnt` are both high. At most one `gnt` is high per cycle.
- FSM state is the current owner: IDLE, OWN0, OWN1. Reset state is IDLE.
- Beat counter `cnt` is 4 bits, reset 0.
- Grant decision, combinational from the state, `cnt` and both `req` signals:
  - Neither master requesting: no grant. Next state is IDLE; `cnt` holds.
  - Only one master requesting: grant it.
  - Both requesting, state IDLE: grant master 0.
  - Both requesting, state OWNx with `cnt < MAX_BURST`: grant x.
  - Both requesting, state OWNx with `cnt >= MAX_BURST`: grant the other master.
- After each beat, the next state is OWN of the granted master.
- Counter update after each beat:
  - If the owner changes, or the previous state was IDLE: `cnt` = 1.
  - Otherwise: `cnt` = min(`cnt` + 1, 15).
- Memory outputs during a beat: driven from the granted master's `addr`, `wdata` and `wr_en`.
- Memory outputs with no grant: `mem_wr_en` = 0, `mem_addr` = 0, `mem_dout` = 0.
- Read tracking:
  - A read beat (`wr_en` == 0) sets `pend_vld` = 1 and `pend_id` = x at the next edge.
  - `mX_rvalid` = `pend_vld & (pend_id == x)`.
  - `busy` = `pend_vld`.
- Write beats produce no `rvalid`.
- Partial or unaligned byte enables pass through unchanged; lane checking belongs downstream.

## Timing
- Reset values, asynchronous: state IDLE, `cnt` 0, `pend_vld` 0, `pend_id` 0. Therefore `m0_rvalid`, `m1_rvalid` and `busy` are 0.
- Combinational outputs under reset follow the IDLE rules.
- Grant latency is 0 cycles: `gnt` rises in the same cycle as `req` when arbitration favours the requester.
- Read latency: `rvalid` and valid `rdata` appear exactly 1 cycle after the read beat.
- Back-to-back reads from alternating masters each return correctly. Only one response is outstanding at a time, because memory latency is 1.
- A read beat and the previous beat's `rvalid` may coincide in the same cycle; both are legal.
- A master may drop `req` without being granted; no beat occurs and no state changes.
- Reset mid-operation: a pending read response is discarded, and `rvalid` never pulses for it.
- Saturation: with `MAX_BURST` = 15, `cnt` saturates at 15 and the handover still occurs.
- With `MAX_BURST` = 1 and both masters requesting continuously, grants alternate every cycle.

## Test plan
- Reset:
  - Stimulus: assert `rst` asynchronously mid-cycle while `m1` has a read outstanding.
  - Required: `m1_rvalid`, `busy` and `mem_wr_en` are 0 immediately. After release with no requests, `mem_addr` = 0 and no `gnt`.
- Single master:
  - Stimulus: `m0` reads 0x100, 0x104, 0x108 in consecutive cycles; memory returns address-as-data.
  - Required: `m0_gnt` is high all 3 cycles, and `m0_rvalid` is high for 3 cycles, delayed by one, with `m0_rdata` = 0x100, 0x104, 0x108.
- Burst limit:
  - Stimulus: `MAX_BURST` = 4; `m0` and `m1` request continuously from IDLE.
  - Required, grant sequence: m0×4, m1×4, m0×4. `m0_stall` is high exactly during the m1 windows.
- Write routing:
  - Stimulus: `m1` writes `wdata` = 0xAABBCCDD with `wr_en` = 4'b0011 to 0x2002 while `m0` is idle.
  - Required: `mem_addr` = 0x2002, `mem_dout` = 0xAABBCCDD and `mem_wr_en` = 4'b0011 in that cycle; no `rvalid` follows.
- Response steering:
  - Stimulus: an `m0` read beat is followed immediately by an `m1` read beat.
  - Required: `m0_rvalid` is high in cycle 2 only, and `m1_rvalid` is high in cycle 3 only. `m1_rvalid` is never high in cycle 2.
- Drop without grant:
  - Stimulus: `m1` raises and drops `req` while `m0` holds the port below the limit.
  - Required: no `m1` beat, `cnt` is unaffected, and ownership stays OWN0.
